// File: rtl/decode_pkg.sv
// Shared encodings for the decode stage: immediate format selects and
// write-back source selects.
package decode_pkg;

    // Immediate format selects (imm_sel_i)
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // Write-back source selects (wd_sel_i); the remaining code selects zero
    localparam logic [1:0] WD_RETURN_PC = 2'b00;
    localparam logic [1:0] WD_ALU       = 2'b01;
    localparam logic [1:0] WD_MEM       = 2'b10;

endpackage

// File: rtl/decode_stage_gen_reg_file.sv
// Architectural register file: two combinational read ports, one write port.
// x0 is hardwired to zero on read and is never written.
module gen_reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NREG];

    // Storage: cleared on reset, written on the rising edge unless the target is x0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: register file read with internal operand
// forwarding, write-back mux, immediate generation, load-use hazard
// detection and the registered ID/EX output.
//
// Handshake: id_ex_valid_o marks the ID/EX contents as a real instruction;
// ex_ready_i=1 means EX takes those contents at this rising edge, so the
// register is only allowed to change on such an edge. id_ready_o=1 means the
// instruction currently in ID is consumed at this edge and IF/ID may advance.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            if_valid_i,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [2:0]      imm_sel_i,
    input  logic            rs1_used_i,
    input  logic            rs2_used_i,
    input  logic            rd_we_i,
    input  logic            we_i,
    input  logic [AW-1:0]   wr_i,
    input  logic [1:0]      wd_sel_i,
    input  logic [XLEN-1:0] return_pc_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic            ex_valid_i,
    input  logic            ex_we_i,
    input  logic            ex_is_load_i,
    input  logic [AW-1:0]   ex_rd_i,
    input  logic [XLEN-1:0] ex_result_i,
    input  logic            mem_valid_i,
    input  logic            mem_we_i,
    input  logic [AW-1:0]   mem_rd_i,
    input  logic [XLEN-1:0] mem_result_i,
    input  logic            flush_i,
    input  logic            ex_ready_i,
    output logic            id_ready_o,
    output logic            stall_o,
    output logic [XLEN-1:0] wd_o,
    output logic            id_ex_valid_o,
    output logic [XLEN-1:0] id_ex_pc_o,
    output logic [XLEN-1:0] id_ex_rd1_o,
    output logic [XLEN-1:0] id_ex_rd2_o,
    output logic [XLEN-1:0] id_ex_ext_o,
    output logic [AW-1:0]   id_ex_rd_o,
    output logic            id_ex_we_o
);

    logic [AW-1:0]          rs1;
    logic [AW-1:0]          rs2;
    logic [AW-1:0]          rd;
    logic [XLEN-1:0]        rf_rd1;
    logic [XLEN-1:0]        rf_rd2;
    logic [XLEN-1:0]        op1;
    logic [XLEN-1:0]        op2;
    logic signed [31:0]     imm32;
    logic signed [XLEN-1:0] imm_ext;
    logic                   unused_opcode;

    assign rs1 = inst_i[15 +: AW];
    assign rs2 = inst_i[20 +: AW];
    assign rd  = inst_i[7 +: AW];

    // Opcode bits are decoded upstream; only the operand/immediate fields matter here
    assign unused_opcode = ^inst_i[6:0];

    gen_reg_file #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_reg_file (
        .clk    (clk_i),
        .rst_n  (reset_i),
        .we     (we_i),
        .waddr  (wr_i),
        .wdata  (wd_o),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2)
    );

    // Write-back data mux; the unused select code yields zero
    always_comb begin
        wd_o = '0;
        case (wd_sel_i)
            WD_RETURN_PC: wd_o = return_pc_i;
            WD_ALU:       wd_o = alu_result_i;
            WD_MEM:       wd_o = mem_data_i;
            default:      wd_o = '0;
        endcase
    end

    // Youngest producer wins: EX (non-load), then MEM, then same-cycle write-back
    function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0]   rs,
                                            input logic [XLEN-1:0] rf_val);
        if (rs == '0)
            return '0;
        else if (ex_valid_i && ex_we_i && !ex_is_load_i && (ex_rd_i == rs))
            return ex_result_i;
        else if (mem_valid_i && mem_we_i && (mem_rd_i == rs))
            return mem_result_i;
        else if (we_i && (wr_i == rs))
            return wd_o;
        else
            return rf_val;
    endfunction

    // Operand selection for both read ports
    always_comb begin
        op1 = fwd(rs1, rf_rd1);
        op2 = fwd(rs2, rf_rd2);
    end

    // Immediate generator: assemble a 32-bit immediate, then sign-extend to XLEN
    always_comb begin
        imm32 = '0;
        case (imm_sel_i)
            IMM_I: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_S: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                            inst_i[30:25], inst_i[11:8], 1'b0};
            IMM_U: imm32 = {inst_i[31:12], 12'b0};
            IMM_J: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                            inst_i[20], inst_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_ext = imm32;

    // A load in EX cannot forward yet; hold the consumer in ID for one cycle
    assign stall_o = if_valid_i && ex_valid_i && ex_is_load_i && ex_we_i &&
                     (ex_rd_i != '0) &&
                     ((rs1_used_i && (rs1 == ex_rd_i)) ||
                      (rs2_used_i && (rs2 == ex_rd_i)));

    assign id_ready_o = ex_ready_i && (!stall_o || flush_i);

    // ID/EX register: hold under backpressure, bubble on flush or stall, else capture
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            id_ex_valid_o <= 1'b0;
            id_ex_pc_o    <= '0;
            id_ex_rd1_o   <= '0;
            id_ex_rd2_o   <= '0;
            id_ex_ext_o   <= '0;
            id_ex_rd_o    <= '0;
            id_ex_we_o    <= 1'b0;
        end else if (ex_ready_i) begin
            if (flush_i || stall_o) begin
                id_ex_valid_o <= 1'b0;
            end else begin
                id_ex_valid_o <= if_valid_i;
                id_ex_pc_o    <= pc_i;
                id_ex_rd1_o   <= op1;
                id_ex_rd2_o   <= op2;
                id_ex_ext_o   <= imm_ext;
                id_ex_rd_o    <= rd;
                id_ex_we_o    <= rd_we_i;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vectors, expected ID/EX contents queued
// by the driver and checked by an independent monitor one edge later.
module tb_decode_stage;
    import decode_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            reset_i;
    logic            if_valid_i;
    logic [31:0]     inst_i;
    logic [XLEN-1:0] pc_i;
    logic [2:0]      imm_sel_i;
    logic            rs1_used_i;
    logic            rs2_used_i;
    logic            rd_we_i;
    logic            we_i;
    logic [AW-1:0]   wr_i;
    logic [1:0]      wd_sel_i;
    logic [XLEN-1:0] return_pc_i;
    logic [XLEN-1:0] alu_result_i;
    logic [XLEN-1:0] mem_data_i;
    logic            ex_valid_i;
    logic            ex_we_i;
    logic            ex_is_load_i;
    logic [AW-1:0]   ex_rd_i;
    logic [XLEN-1:0] ex_result_i;
    logic            mem_valid_i;
    logic            mem_we_i;
    logic [AW-1:0]   mem_rd_i;
    logic [XLEN-1:0] mem_result_i;
    logic            flush_i;
    logic            ex_ready_i;
    logic            id_ready_o;
    logic            stall_o;
    logic [XLEN-1:0] wd_o;
    logic            id_ex_valid_o;
    logic [XLEN-1:0] id_ex_pc_o;
    logic [XLEN-1:0] id_ex_rd1_o;
    logic [XLEN-1:0] id_ex_rd2_o;
    logic [XLEN-1:0] id_ex_ext_o;
    logic [AW-1:0]   id_ex_rd_o;
    logic            id_ex_we_o;

    typedef struct packed {
        logic        valid;
        logic        chk;      // 0: only the valid bit is meaningful (bubble)
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    decode_stage #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .if_valid_i    (if_valid_i),
        .inst_i        (inst_i),
        .pc_i          (pc_i),
        .imm_sel_i     (imm_sel_i),
        .rs1_used_i    (rs1_used_i),
        .rs2_used_i    (rs2_used_i),
        .rd_we_i       (rd_we_i),
        .we_i          (we_i),
        .wr_i          (wr_i),
        .wd_sel_i      (wd_sel_i),
        .return_pc_i   (return_pc_i),
        .alu_result_i  (alu_result_i),
        .mem_data_i    (mem_data_i),
        .ex_valid_i    (ex_valid_i),
        .ex_we_i       (ex_we_i),
        .ex_is_load_i  (ex_is_load_i),
        .ex_rd_i       (ex_rd_i),
        .ex_result_i   (ex_result_i),
        .mem_valid_i   (mem_valid_i),
        .mem_we_i      (mem_we_i),
        .mem_rd_i      (mem_rd_i),
        .mem_result_i  (mem_result_i),
        .flush_i       (flush_i),
        .ex_ready_i    (ex_ready_i),
        .id_ready_o    (id_ready_o),
        .stall_o       (stall_o),
        .wd_o          (wd_o),
        .id_ex_valid_o (id_ex_valid_o),
        .id_ex_pc_o    (id_ex_pc_o),
        .id_ex_rd1_o   (id_ex_rd1_o),
        .id_ex_rd2_o   (id_ex_rd2_o),
        .id_ex_ext_o   (id_ex_ext_o),
        .id_ex_rd_o    (id_ex_rd_o),
        .id_ex_we_o    (id_ex_we_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_inst(input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [4:0] rd);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_side();
        we_i         = 1'b0;
        wr_i         = '0;
        wd_sel_i     = WD_ALU;
        return_pc_i  = '0;
        alu_result_i = '0;
        mem_data_i   = '0;
        ex_valid_i   = 1'b0;
        ex_we_i      = 1'b0;
        ex_is_load_i = 1'b0;
        ex_rd_i      = '0;
        ex_result_i  = '0;
        mem_valid_i  = 1'b0;
        mem_we_i     = 1'b0;
        mem_rd_i     = '0;
        mem_result_i = '0;
        flush_i      = 1'b0;
        ex_ready_i   = 1'b1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                          input logic [2:0] sel, input logic u1, input logic u2,
                          input logic rdwe);
        if_valid_i = v;
        inst_i     = inst;
        pc_i       = pc;
        imm_sel_i  = sel;
        rs1_used_i = u1;
        rs2_used_i = u2;
        rd_we_i    = rdwe;
    endtask

    task automatic push(input logic v, input logic chk, input logic [31:0] pc,
                        input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] ext, input logic [4:0] rd, input logic we);
        exp_t e;
        e.valid = v;
        e.chk   = chk;
        e.pc    = pc;
        e.rd1   = rd1;
        e.rd2   = rd2;
        e.ext   = ext;
        e.rd    = rd;
        e.we    = we;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("id_ex_valid", {31'd0, id_ex_valid_o}, {31'd0, e.valid});
            if (e.chk) begin
                check("id_ex_pc",  id_ex_pc_o,  e.pc);
                check("id_ex_rd1", id_ex_rd1_o, e.rd1);
                check("id_ex_rd2", id_ex_rd2_o, e.rd2);
                check("id_ex_ext", id_ex_ext_o, e.ext);
                check("id_ex_rd",  {27'd0, id_ex_rd_o}, {27'd0, e.rd});
                check("id_ex_we",  {31'd0, id_ex_we_o}, {31'd0, e.we});
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #50000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] imm_inst [6];
        logic [2:0]  imm_sel  [6];
        logic [31:0] imm_exp  [6];
        logic [4:0]  imm_rd   [6];

        imm_inst[0] = 32'hFFF00093; imm_sel[0] = IMM_I; imm_exp[0] = 32'hFFFFFFFF; imm_rd[0] = 5'd1;
        imm_inst[1] = 32'hFE000EE3; imm_sel[1] = IMM_B; imm_exp[1] = 32'hFFFFFFFC; imm_rd[1] = 5'd29;
        imm_inst[2] = 32'h123450B7; imm_sel[2] = IMM_U; imm_exp[2] = 32'h12345000; imm_rd[2] = 5'd1;
        imm_inst[3] = 32'hFFF00093; imm_sel[3] = 3'd7;  imm_exp[3] = 32'h00000000; imm_rd[3] = 5'd1;
        imm_inst[4] = 32'hFE000EA3; imm_sel[4] = IMM_S; imm_exp[4] = 32'hFFFFFFFD; imm_rd[4] = 5'd29;
        imm_inst[5] = 32'h0040006F; imm_sel[5] = IMM_J; imm_exp[5] = 32'h00000004; imm_rd[5] = 5'd0;

        reset_i = 1'b0;
        clear_side();
        set_id(1'b0, 32'd0, 32'd0, 3'd7, 1'b0, 1'b0, 1'b0);
        #2;
        check("reset_valid", {31'd0, id_ex_valid_o}, 32'd0);
        check("reset_pc",    id_ex_pc_o, 32'd0);
        check("reset_rd1",   id_ex_rd1_o, 32'd0);
        check("reset_we",    {31'd0, id_ex_we_o}, 32'd0);
        check("reset_stall", {31'd0, stall_o}, 32'd0);
        check("reset_ready", {31'd0, id_ready_o}, 32'd1);

        @(negedge clk);
        reset_i = 1'b1;

        // write-back mux sources, then write x5=0x55
        we_i = 1'b0;
        wd_sel_i = WD_RETURN_PC; return_pc_i = 32'h1111; mem_data_i = 32'h2222;
        #1 check("wd_return_pc", wd_o, 32'h1111);
        wd_sel_i = WD_MEM;
        #1 check("wd_mem", wd_o, 32'h2222);
        wd_sel_i = 2'b11;
        #1 check("wd_zero", wd_o, 32'h0);
        we_i = 1'b1; wr_i = 5'd5; wd_sel_i = WD_ALU; alu_result_i = 32'h55;
        #1 check("wd_alu", wd_o, 32'h55);
        step();

        // read x5 back through the register file
        clear_side();
        set_id(1'b1, r_inst(5'd5, 5'd0, 5'd1), 32'h100, 3'd7, 1'b1, 1'b0, 1'b1);
        push(1'b1, 1'b1, 32'h100, 32'h55, 32'h0, 32'h0, 5'd1, 1'b1);
        #1 check("no_stall", {31'd0, stall_o}, 32'd0);
        check("ready_idle", {31'd0, id_ready_o}, 32'd1);
        step();

        // mid-stream reset clears ID/EX and the register file
        reset_i = 1'b0;
        #1;
        check("midrst_valid", {31'd0, id_ex_valid_o}, 32'd0);
        check("midrst_pc",    id_ex_pc_o, 32'd0);
        check("midrst_rd1",   id_ex_rd1_o, 32'd0);
        check("midrst_rd",    {27'd0, id_ex_rd_o}, 32'd0);
        set_id(1'b1, r_inst(5'd5, 5'd0, 5'd2), 32'h104, 3'd7, 1'b1, 1'b0, 1'b1);
        #1 reset_i = 1'b1;
        push(1'b1, 1'b1, 32'h104, 32'h0, 32'h0, 32'h0, 5'd2, 1'b1);
        step();

        // write-through: same-cycle write-back of x5 is seen by the read
        we_i = 1'b1; wr_i = 5'd5; wd_sel_i = WD_ALU; alu_result_i = 32'h1234;
        set_id(1'b1, r_inst(5'd5, 5'd0, 5'd3), 32'h108, 3'd7, 1'b1, 1'b0, 1'b1);
        push(1'b1, 1'b1, 32'h108, 32'h1234, 32'h0, 32'h0, 5'd3, 1'b1);
        step();

        clear_side();
        set_id(1'b1, r_inst(5'd5, 5'd5, 5'd4), 32'h10C, 3'd7, 1'b1, 1'b1, 1'b0);
        push(1'b1, 1'b1, 32'h10C, 32'h1234, 32'h1234, 32'h0, 5'd4, 1'b0);
        step();

        // EX beats MEM
        ex_valid_i = 1'b1; ex_we_i = 1'b1; ex_rd_i = 5'd3; ex_result_i = 32'hA;
        mem_valid_i = 1'b1; mem_we_i = 1'b1; mem_rd_i = 5'd3; mem_result_i = 32'hB;
        set_id(1'b1, r_inst(5'd3, 5'd3, 5'd6), 32'h110, 3'd7, 1'b1, 1'b1, 1'b1);
        push(1'b1, 1'b1, 32'h110, 32'hA, 32'hA, 32'h0, 5'd6, 1'b1);
        step();

        // MEM alone
        ex_valid_i = 1'b0;
        set_id(1'b1, r_inst(5'd3, 5'd3, 5'd6), 32'h114, 3'd7, 1'b1, 1'b1, 1'b1);
        push(1'b1, 1'b1, 32'h114, 32'hB, 32'hB, 32'h0, 5'd6, 1'b1);
        step();

        // x0 never forwards, even with producers targeting x0
        ex_valid_i = 1'b1; ex_we_i = 1'b1; ex_rd_i = 5'd0; ex_result_i = 32'hAAAA;
        mem_valid_i = 1'b1; mem_we_i = 1'b1; mem_rd_i = 5'd0; mem_result_i = 32'hBBBB;
        we_i = 1'b1; wr_i = 5'd0; wd_sel_i = WD_ALU; alu_result_i = 32'hDEAD;
        set_id(1'b1, r_inst(5'd0, 5'd0, 5'd7), 32'h118, 3'd7, 1'b1, 1'b1, 1'b1);
        push(1'b1, 1'b1, 32'h118, 32'h0, 32'h0, 32'h0, 5'd7, 1'b1);
        step();

        // load-use: one bubble, then MEM forwards the load data
        clear_side();
        ex_valid_i = 1'b1; ex_we_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd7;
        set_id(1'b1, r_inst(5'd0, 5'd7, 5'd10), 32'h120, 3'd7, 1'b0, 1'b1, 1'b1);
        #1 check("lu_stall", {31'd0, stall_o}, 32'd1);
        check("lu_ready", {31'd0, id_ready_o}, 32'd0);
        push(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        step();

        clear_side();
        mem_valid_i = 1'b1; mem_we_i = 1'b1; mem_rd_i = 5'd7; mem_result_i = 32'h77;
        #1 check("lu2_stall", {31'd0, stall_o}, 32'd0);
        check("lu2_ready", {31'd0, id_ready_o}, 32'd1);
        push(1'b1, 1'b1, 32'h120, 32'h0, 32'h77, 32'h0, 5'd10, 1'b1);
        step();

        // flush together with stall: flush wins
        clear_side();
        ex_valid_i = 1'b1; ex_we_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = 5'd7;
        flush_i = 1'b1;
        set_id(1'b1, r_inst(5'd0, 5'd7, 5'd11), 32'h124, 3'd7, 1'b0, 1'b1, 1'b1);
        #1 check("fl_stall", {31'd0, stall_o}, 32'd1);
        check("fl_ready", {31'd0, id_ready_o}, 32'd1);
        push(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        step();

        // backpressure: load a known instruction, then hold for 3 cycles
        clear_side();
        set_id(1'b1, r_inst(5'd5, 5'd0, 5'd9), 32'h400, 3'd7, 1'b1, 1'b0, 1'b1);
        push(1'b1, 1'b1, 32'h400, 32'h1234, 32'h0, 32'h0, 5'd9, 1'b1);
        step();

        for (int i = 0; i < 3; i++) begin
            ex_ready_i = 1'b0;
            set_id(1'b1, 32'h123450B7, 32'h500 + 32'(i * 4), IMM_U, 1'b1, 1'b1, 1'b0);
            #1 check("hold_ready", {31'd0, id_ready_o}, 32'd0);
            push(1'b1, 1'b1, 32'h400, 32'h1234, 32'h0, 32'h0, 5'd9, 1'b1);
            step();
        end

        // immediate formats
        clear_side();
        for (int i = 0; i < 6; i++) begin
            set_id(1'b1, imm_inst[i], 32'h600 + 32'(i * 4), imm_sel[i], 1'b1, 1'b1, 1'b1);
            push(1'b1, 1'b1, 32'h600 + 32'(i * 4), 32'h0, 32'h0, imm_exp[i], imm_rd[i], 1'b1);
            step();
        end

        set_id(1'b0, 32'd0, 32'd0, 3'd7, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() != 0) step();
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
